rpn_calc_ctrl: RTL and testbench
================================

RPN_CALC_CTRL -- requirements
Module: rpn_calc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width of operands, results and LIFO data.
REQ-002 Parameter DEPTH, default 8: capacity of the attached LIFO, mirrored in an internal occupancy counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset, shared with the attached LIFO.
REQ-005 tok_valid  in  1  token present; tok_ready  out  1  token accepted when both are high at a clock edge.
REQ-006 tok_is_op  in  1  1 = opcode token, 0 = operand token; tok_data  in  WIDTH  operand value or opcode (low 4 bits).
REQ-007 res_valid  out  1  one-cycle result pulse; res_data  out  WIDTH  result value.
REQ-008 err_ovf, err_udf, err_op  out  1 each  one-cycle error pulses; busy  out  1  high whenever state is not IDLE.
REQ-009 lifo_in  out  WIDTH; lifo_wn  out  1; lifo_rn  out  1: push data, push strobe and pop strobe to the LIFO.
REQ-010 lifo_out  in  WIDTH; lifo_full  in  1; lifo_empty  in  1: LIFO outputs.

Function
REQ-011 tok_ready SHALL equal (state==IDLE) and not rst; tokens are accepted only in IDLE.
REQ-012 FSM states: IDLE, PUSH, POP_B, WAIT_B, POP_A, WAIT_A, RESULT, ERR; all LIFO strobes and outputs are registered.
REQ-013 Operand token, count<DEPTH and lifo_full=0: IDLE->PUSH; PUSH drives lifo_wn=1 and lifo_in=operand for exactly one cycle; count+1; ->IDLE.
REQ-014 Operand token, count==DEPTH or lifo_full=1: token dropped; ERR pulses err_ovf for one cycle; stack unchanged; ->IDLE.
REQ-015 Opcodes: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 MUL (see REQ-024), F EQ; a = second-from-top entry, b = top entry.
REQ-016 Binary opcode, count>=2: POP_B (lifo_rn=1) -> WAIT_B (b captured from lifo_out) -> POP_A (lifo_rn=1) -> WAIT_A (a captured) -> PUSH (result) -> IDLE; count-1 net.
REQ-017 lifo_out SHALL be sampled on the clock edge ending the cycle after the one in which lifo_rn was high.
REQ-018 EQ opcode, count>=1: POP_B -> WAIT_B -> RESULT; RESULT drives res_valid=1, res_data=b for one cycle; count-1.
REQ-019 Binary opcode with count<2, or EQ with count==0: no LIFO access; err_udf pulses for one cycle via ERR.
REQ-020 Undefined opcode: no LIFO access; err_op pulses for one cycle via ERR.
REQ-021 Arithmetic is modulo 2^WIDTH: no carry, no saturation; MUL keeps the low WIDTH bits.
REQ-022 Latency from acceptance: operand 2 cycles, binary op 6, EQ 4, any error 2; never more than one strobe high per cycle.

Reset
REQ-023 rst high at any time, including mid-operation: state=IDLE, count=0, captured a/b=0, and lifo_in, lifo_wn, lifo_rn, res_valid, res_data, err_* and busy all 0; any in-flight token is abandoned.

Configuration
REQ-024 With macro RPN_MUL_EN defined, opcode 5 is MUL; without it, opcode 5 is undefined and handled per REQ-020.

Structure
REQ-025 Shared package rpn_pkg SHALL hold the opcode constants, the FSM state encoding and the default WIDTH and DEPTH.
REQ-026 One combinational sub-module rpn_alu (inputs a, b, op; outputs result and illegal) SHALL implement REQ-015, REQ-021 and REQ-024.

Verification (bench pairs the block with the 8-bit LIFO)
REQ-027 Push 100, 150, ADD, EQ -> res_valid pulse with res_data=250; stack empty afterwards (lifo_empty=1).
REQ-028 Push 200, 70, SUB, EQ -> 130; then push 10, 20, SUB, EQ -> 246 (wrap-around).
REQ-029 After reset, push 5, ADD -> err_udf pulse and no LIFO strobes; then EQ -> res_data=5; then EQ -> err_udf.
REQ-030 Push 1..8 (DEPTH=8), then push 9 -> err_ovf pulse; then EQ -> res_data=8.
REQ-031 Opcode 9 -> err_op pulse; push 15, 17, opcode 5, EQ -> 255 with RPN_MUL_EN defined, and err_op without it.
REQ-032 Push 3, 4, ADD, with rst asserted during WAIT_A -> all outputs 0 immediately; after release, EQ -> err_udf.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared opcode constants, FSM state encoding and default WIDTH/DEPTH for the RPN calculator
package rpn_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;
    localparam logic [3:0] OP_EQ  = 4'hF;
    typedef enum logic [2:0] {IDLE, PUSH, POP_B, WAIT_B, POP_A, WAIT_A, RESULT, ERR} state_t;
endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational opcode evaluator (ports a, b, op in; result, illegal out), modulo 2^WIDTH; RPN_MUL_EN makes opcode 5 MUL
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
`ifdef RPN_MUL_EN
            OP_MUL: result = a * b;
`endif
            OP_EQ:  result = b;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/rpn_calc_ctrl.sv
// rpn_calc_ctrl: RPN token controller over an external LIFO; tok_* handshake in, res_*/err_*/busy out, lifo_in/wn/rn to and lifo_out/full/empty from the LIFO; RPN_MUL_EN enables opcode 5 MUL
module rpn_calc_ctrl
    import rpn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             err_ovf,
    output logic             err_udf,
    output logic             err_op,
    output logic             busy,
    output logic [WIDTH-1:0] lifo_in,
    output logic             lifo_wn,
    output logic             lifo_rn,
    input  logic [WIDTH-1:0] lifo_out,
    input  logic             lifo_full,
    input  logic             lifo_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    state_t         state;
    logic [CW-1:0]  count;
    logic [WIDTH-1:0] b_q;
    logic [3:0]     op_q;
    logic [WIDTH-1:0] alu_res;
    logic           illegal;
    logic [CW-1:0]  need;
    // In IDLE the ALU only classifies the incoming opcode; in WAIT_A it computes a (live lifo_out) op b.
    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a(lifo_out),
        .b(b_q),
        .op(state == IDLE ? tok_data[3:0] : op_q),
        .result(alu_res),
        .illegal(illegal)
    );
    assign tok_ready = (state == IDLE) && !rst;
    assign need = (tok_data[3:0] == OP_EQ) ? CW'(1) : CW'(2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            b_q       <= '0;
            op_q      <= '0;
            lifo_in   <= '0;
            lifo_wn   <= 1'b0;
            lifo_rn   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
            err_op    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            lifo_wn   <= 1'b0;
            lifo_rn   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
            err_op    <= 1'b0;
            case (state)
                IDLE: if (tok_valid) begin
                    busy <= 1'b1;
                    if (!tok_is_op) begin
                        if (count == CW'(DEPTH) || lifo_full) begin
                            state   <= ERR;
                            err_ovf <= 1'b1;
                        end else begin
                            state   <= PUSH;
                            lifo_wn <= 1'b1;
                            lifo_in <= tok_data;
                            count   <= count + CW'(1);
                        end
                    end else if (illegal) begin
                        state  <= ERR;
                        err_op <= 1'b1;
                    end else if (count < need || lifo_empty) begin
                        state   <= ERR;
                        err_udf <= 1'b1;
                    end else begin
                        // Binary ops pop two and push one, EQ pops one: both are net -1.
                        state   <= POP_B;
                        lifo_rn <= 1'b1;
                        op_q    <= tok_data[3:0];
                        count   <= count - CW'(1);
                    end
                end
                POP_B: state <= WAIT_B;
                WAIT_B: begin
                    b_q <= lifo_out;
                    if (op_q == OP_EQ) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        res_data  <= lifo_out;
                    end else begin
                        state   <= POP_A;
                        lifo_rn <= 1'b1;
                    end
                end
                POP_A: state <= WAIT_A;
                WAIT_A: begin
                    state   <= PUSH;
                    lifo_wn <= 1'b1;
                    lifo_in <= alu_res;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_calc_ctrl.sv
// tb_rpn_calc_ctrl: directed and random token sequences against a queue-based RPN model, with an 8-deep LIFO attached
module tb_rpn_calc_ctrl;
`ifdef RPN_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tok_valid = 1'b0;
    logic       tok_is_op = 1'b0;
    logic [7:0] tok_data = '0;
    logic       tok_ready, res_valid, err_ovf, err_udf, err_op, busy, lifo_wn, lifo_rn;
    logic [7:0] res_data, lifo_in, lifo_out;
    logic       lifo_full, lifo_empty;
    int         total = 0;
    int         bad = 0;
    logic [7:0] mem [8];
    int         sp;
    logic [7:0] mdl [$];

    rpn_calc_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
        .res_valid(res_valid), .res_data(res_data),
        .err_ovf(err_ovf), .err_udf(err_udf), .err_op(err_op), .busy(busy),
        .lifo_in(lifo_in), .lifo_wn(lifo_wn), .lifo_rn(lifo_rn),
        .lifo_out(lifo_out), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp       <= 0;
            lifo_out <= '0;
        end else if (lifo_wn && sp < 8) begin
            mem[sp] <= lifo_in;
            sp      <= sp + 1;
        end else if (lifo_rn && sp > 0) begin
            lifo_out <= mem[sp-1];
            sp       <= sp - 1;
        end
    end
    assign lifo_full  = (sp == 8);
    assign lifo_empty = (sp == 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"}, {15'd0, lifo_in, lifo_wn, lifo_rn, res_valid, res_data, err_ovf, err_udf, err_op, busy}, 0);
        check({tag, "_ready"}, 32'(tok_ready), 0);
    endtask

    function automatic logic [7:0] calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0: return 8'(a + b);
            4'd1: return 8'(a - b);
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            default: return 8'(a * b);
        endcase
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero(tag);
        mdl.delete();
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(tok_ready), 1);
    endtask

    task automatic send(input bit is_op, input logic [7:0] d);
        int e_lat = 2, e_resn = 0, e_ovf = 0, e_udf = 0, e_op = 0, e_wn = 0, e_rn = 0;
        int lat = 0, resn = 0, ovf = 0, udf = 0, eop = 0, wn = 0, rn = 0, multi = 0, n = 0;
        logic [7:0] e_res = '0, got_res = '0, a, b;
        logic [3:0] op = d[3:0];
        string t = $sformatf("%s_%0h", is_op ? "op" : "val", d);
        if (!is_op) begin
            if (mdl.size() == 8) e_ovf = 1;
            else begin mdl.push_back(d); e_wn = 1; end
        end else if (!(op <= 4'd4 || op == 4'hF || (op == 4'd5 && MUL))) e_op = 1;
        else if (op == 4'hF) begin
            if (mdl.size() >= 1) begin
                e_res = mdl.pop_back(); e_resn = 1; e_rn = 1; e_lat = 4;
            end else e_udf = 1;
        end else if (mdl.size() >= 2) begin
            b = mdl.pop_back(); a = mdl.pop_back();
            mdl.push_back(calc(op, a, b)); e_rn = 2; e_wn = 1; e_lat = 6;
        end else e_udf = 1;
        while (!tok_ready && n < 20) begin @(negedge clk); n++; end
        check({t, "_ready_wait"}, 32'(tok_ready), 1);
        tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tok_valid = 1'b0;
            if (tok_ready && lat == 0) lat = k;
            if (res_valid) begin resn++; got_res = res_data; end
            ovf += int'(err_ovf); udf += int'(err_udf); eop += int'(err_op);
            wn += int'(lifo_wn); rn += int'(lifo_rn); multi += int'(lifo_wn && lifo_rn);
        end
        check({t, "_latency"}, lat, e_lat);
        check({t, "_res_n"}, resn, e_resn);
        if (e_resn == 1) check({t, "_res_data"}, 32'(got_res), 32'(e_res));
        check({t, "_ovf"}, ovf, e_ovf);
        check({t, "_udf"}, udf, e_udf);
        check({t, "_errop"}, eop, e_op);
        check({t, "_wn"}, wn, e_wn);
        check({t, "_rn"}, rn, e_rn);
        check({t, "_multi"}, multi, 0);
        check({t, "_busy_idle"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(tok_ready), 1);
        send(0, 8'd100); send(0, 8'd150); send(1, 8'h00); send(1, 8'h0F);
        check("sum_empty", 32'(lifo_empty), 1);
        send(0, 8'd200); send(0, 8'd70); send(1, 8'h01); send(1, 8'h0F);
        send(0, 8'd10); send(0, 8'd20); send(1, 8'h01); send(1, 8'h0F);
        do_reset("rst_a");
        send(0, 8'd5); send(1, 8'h00); send(1, 8'h0F); send(1, 8'h0F);
        for (int i = 1; i <= 9; i++) send(0, 8'(i));
        check("ovf_full", 32'(lifo_full), 1);
        send(1, 8'h0F);
        do_reset("rst_b");
        send(1, 8'h09);
        send(0, 8'd15); send(0, 8'd17); send(1, 8'h05); send(1, 8'h0F);
        do_reset("rst_c");
        send(0, 8'd3); send(0, 8'd4);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tok_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_a_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        mdl.delete();
        @(negedge clk);
        rst = 1'b0;
        send(1, 8'h0F);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 55) send(0, 8'($urandom));
            else if ($urandom_range(0, 3) == 0) send(1, {4'($urandom), 4'($urandom)});
            else begin
                logic [3:0] ops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF};
                send(1, {4'($urandom), ops[$urandom_range(0, 6)]});
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
